// File: rtl/ones_cnt_pkg.sv
// rtl/ones_cnt_pkg.sv - shared types and helpers for the ones-counter scheduler
package ones_cnt_pkg;

   typedef enum logic [2:0] {IDLE, CLR, SHIFT, CAPT, RESP} state_t;

   localparam int CNT_W = 4;
   localparam int MAX_W = 16;

   // Words are zero-extended to MAX_W before counting.
   function automatic logic [CNT_W-1:0] popcount(input logic [MAX_W-1:0] w);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < MAX_W; i++) begin
         c = c + CNT_W'(w[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with rotating start pointer
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic                 advance,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx
);

   localparam int IW = $clog2(N);
   localparam int SW = IW + 1;

   logic [IW-1:0] ptr;
   logic [N-1:0]  rot;
   logic [SW-1:0] sum;
   logic          any;

   // rot[i] is the request at position (ptr + i) mod N; lowest set i wins.
   always_comb begin
      rot = N'({req, req} >> ptr);
      sum = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            sum = SW'(ptr) + SW'(i);
            any = 1'b1;
         end
      end
      grant_idx = (sum >= SW'(N)) ? IW'(sum - SW'(N)) : IW'(sum);
      grant     = any ? (N'(1) << grant_idx) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
      end
   end

endmodule

// File: rtl/ones_cnt_sched.sv
// rtl/ones_cnt_sched.sv - shares one serial ones-counter among NUM_REQ requesters
module ones_cnt_sched
   import ones_cnt_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       cnt_reset,
   output logic                       cnt_data,
   input  logic [0:3]                 cnt_count,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [3:0]                 rsp_count,
   output logic                       rsp_mismatch,
   output logic                       busy
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int BIT_W = $clog2(DATA_W + 1);

   state_t             state, state_nx;
   logic [NUM_REQ-1:0] idle_req;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               xfer;
   logic               last_bit;
   logic [DATA_W-1:0]  sel_word;
   logic [DATA_W-1:0]  shreg;
   logic [BIT_W-1:0]   bit_idx;
   logic [CNT_W-1:0]   pop_q;
   logic [CNT_W-1:0]   cap;

   assign idle_req = req_valid & {NUM_REQ{(state == IDLE) && !reset}};

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (idle_req),
      .advance   (xfer),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready = grant;
   assign xfer      = |grant;
   assign last_bit  = (bit_idx == BIT_W'(DATA_W - 1));

   always_comb begin
      sel_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) sel_word = req_data[i*DATA_W +: DATA_W];
      end
   end

   // The counter presents index 0 as its MSB; flip into MSB-at-3 order.
   always_comb begin
      cap = '0;
      for (int i = 0; i < CNT_W; i++) begin
         cap[CNT_W-1-i] = cnt_count[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (xfer) state_nx = CLR;
         CLR:     state_nx = SHIFT;
         SHIFT:   if (last_bit) state_nx = CAPT;
         CAPT:    state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      cnt_reset = reset | (state == CLR);
      cnt_data  = (state == SHIFT) & shreg[0];
      rsp_valid = (state == RESP);
      busy      = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg        <= '0;
         bit_idx      <= '0;
         pop_q        <= '0;
         rsp_id       <= '0;
         rsp_count    <= '0;
         rsp_mismatch <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (xfer) begin
                  shreg   <= sel_word;
                  bit_idx <= '0;
                  rsp_id  <= grant_idx;
                  pop_q   <= popcount(MAX_W'(sel_word));
               end
            end
            SHIFT: begin
               shreg   <= shreg >> 1;
               bit_idx <= bit_idx + BIT_W'(1);
            end
            CAPT: begin
               rsp_count    <= cap;
               rsp_mismatch <= (cap != pop_q);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ones_cnt_sched.sv
// tb/tb_ones_cnt_sched.sv - directed self-checking bench for ones_cnt_sched
module tb_ones_cnt_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        rsp_ready;
   logic        fault;
   int          total = 0;
   int          bad   = 0;

   logic [3:0]  req_valid8;
   logic [31:0] req_data8;
   logic [3:0]  req_ready8;
   logic        cnt_reset8, cnt_data8;
   logic [0:3]  cnt_count8;
   logic        rsp_valid8, rsp_mismatch8, busy8;
   logic [1:0]  rsp_id8;
   logic [3:0]  rsp_count8;
   logic [3:0]  c8;

   logic [3:0]  req_valid15;
   logic [59:0] req_data15;
   logic [3:0]  req_ready15;
   logic        cnt_reset15, cnt_data15;
   logic [0:3]  cnt_count15;
   logic        rsp_valid15, rsp_mismatch15, busy15;
   logic [1:0]  rsp_id15;
   logic [3:0]  rsp_count15;
   logic [3:0]  c15;

   always #5 clk = ~clk;

   ones_cnt_sched #(.NUM_REQ(4), .DATA_W(8)) dut8 (
      .clk(clk), .reset(reset), .req_valid(req_valid8), .req_data(req_data8),
      .req_ready(req_ready8), .cnt_reset(cnt_reset8), .cnt_data(cnt_data8),
      .cnt_count(cnt_count8), .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id8), .rsp_count(rsp_count8), .rsp_mismatch(rsp_mismatch8),
      .busy(busy8)
   );

   ones_cnt_sched #(.NUM_REQ(4), .DATA_W(15)) dut15 (
      .clk(clk), .reset(reset), .req_valid(req_valid15), .req_data(req_data15),
      .req_ready(req_ready15), .cnt_reset(cnt_reset15), .cnt_data(cnt_data15),
      .cnt_count(cnt_count15), .rsp_valid(rsp_valid15), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id15), .rsp_count(rsp_count15), .rsp_mismatch(rsp_mismatch15),
      .busy(busy15)
   );

   // Counter models; the faulty variant adds an extra increment per one-bit.
   always_ff @(posedge clk) begin
      if (cnt_reset8)     c8 <= 4'd0;
      else if (cnt_data8) c8 <= c8 + (fault ? 4'd2 : 4'd1);
      if (cnt_reset15)     c15 <= 4'd0;
      else if (cnt_data15) c15 <= c15 + 4'd1;
   end
   assign cnt_count8  = c8;
   assign cnt_count15 = c15;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic xact8(input int r, input logic [7:0] w, input int exp_cnt, input int exp_mm);
      int n;
      @(negedge clk);
      req_data8[r*8 +: 8] = w;
      req_valid8[r] = 1'b1;
      #1;
      n = 0;
      while (req_ready8[r] !== 1'b1 && n < 50) begin
         @(negedge clk); #1; n++;
      end
      check("grant8", n < 50, 1);
      @(negedge clk);
      req_valid8[r] = 1'b0;
      n = 0;
      while (rsp_valid8 !== 1'b1 && n < 50) begin
         @(negedge clk); n++;
      end
      check("rsp_valid8", rsp_valid8, 1);
      check("rsp_id8", rsp_id8, r);
      check("rsp_count8", rsp_count8, exp_cnt);
      check("rsp_mismatch8", rsp_mismatch8, exp_mm);
   endtask

   task automatic xact15(input int r, input logic [14:0] w, input int exp_cnt);
      int n;
      @(negedge clk);
      req_data15[r*15 +: 15] = w;
      req_valid15[r] = 1'b1;
      #1;
      n = 0;
      while (req_ready15[r] !== 1'b1 && n < 50) begin
         @(negedge clk); #1; n++;
      end
      check("grant15", n < 50, 1);
      @(negedge clk);
      req_valid15[r] = 1'b0;
      n = 0;
      while (rsp_valid15 !== 1'b1 && n < 60) begin
         @(negedge clk); n++;
      end
      check("rsp_valid15", rsp_valid15, 1);
      check("rsp_count15", rsp_count15, exp_cnt);
      check("rsp_mismatch15", rsp_mismatch15, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [7:0]  w;
      logic [3:0]  exp_rr [5];
      logic [3:0]  exp_cnt_rr [5];

      reset = 1'b1; rsp_ready = 1'b1; fault = 1'b0;
      req_valid8 = '0; req_data8 = '0; req_valid15 = '0; req_data15 = '0;
      repeat (2) @(negedge clk);
      check("rst_cnt_reset", cnt_reset8, 1);
      check("rst_cnt_data", cnt_data8, 0);
      check("rst_req_ready", req_ready8, 0);
      check("rst_rsp_valid", rsp_valid8, 0);
      check("rst_rsp_id", rsp_id8, 0);
      check("rst_rsp_count", rsp_count8, 0);
      check("rst_rsp_mismatch", rsp_mismatch8, 0);
      check("rst_busy", busy8, 0);
      check("rst_busy15", busy15, 0);
      reset = 1'b0;

      // All four requesters valid: grants 0,1,2,3,0 with counts of 01,03,07,FF.
      @(negedge clk);
      req_data8 = {8'hFF, 8'h07, 8'h03, 8'h01};
      req_valid8 = 4'hF;
      exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_cnt_rr = '{4'd1, 4'd2, 4'd3, 4'd8, 4'd1};
      for (int g = 0; g < 5; g++) begin
         #1;
         n = 0;
         while (req_ready8 === 4'b0000 && n < 50) begin
            @(negedge clk); #1; n++;
         end
         check("rr_grant", req_ready8, exp_rr[g]);
         @(negedge clk);
         n = 0;
         while (rsp_valid8 !== 1'b1 && n < 50) begin
            @(negedge clk); n++;
         end
         check("rr_rsp_id", rsp_id8, g % 4);
         check("rr_rsp_count", rsp_count8, exp_cnt_rr[g]);
         @(negedge clk);
      end
      req_valid8 = '0;

      // Single request from requester 2 with cycle-accurate shift checks.
      @(negedge clk);
      w = 8'b1011_0110;
      req_data8[16 +: 8] = w;
      req_valid8 = 4'b0100;
      #1;
      check("single_ready", req_ready8, 4'b0100);
      for (n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) begin
            check("clr_cnt_reset", cnt_reset8, 1);
            check("clr_cnt_data", cnt_data8, 0);
            req_valid8 = '0;
         end
         if (n >= 2 && n <= 9) check("shift_bit", cnt_data8, w[n-2]);
         if (n == 10) check("capt_cnt_data", cnt_data8, 0);
         if (rsp_valid8 === 1'b1) break;
      end
      check("rsp_latency", n, 11);
      check("single_id", rsp_id8, 2);
      check("single_count", rsp_count8, 5);
      check("single_mismatch", rsp_mismatch8, 0);
      @(negedge clk);
      check("back_idle", busy8, 0);

      // Faulty counter: two one-bits counted as four.
      fault = 1'b1;
      xact8(0, 8'h03, 4, 1);
      fault = 1'b0;

      // Backpressure with requester 3 waiting behind requester 1.
      @(negedge clk);
      rsp_ready = 1'b0;
      req_data8[8 +: 8]  = 8'h0F;
      req_data8[24 +: 8] = 8'hF0;
      req_valid8 = 4'b1010;
      #1;
      check("bp_grant1", req_ready8, 4'b0010);
      @(negedge clk);
      req_valid8[1] = 1'b0;
      n = 0;
      while (rsp_valid8 !== 1'b1 && n < 50) begin
         @(negedge clk); n++;
      end
      check("bp_rsp_valid", rsp_valid8, 1);
      for (int k = 0; k < 20; k++) begin
         check("bp_hold_valid", rsp_valid8, 1);
         check("bp_hold_id", rsp_id8, 1);
         check("bp_hold_count", rsp_count8, 4);
         check("bp_hold_ready", req_ready8, 0);
         check("bp_hold_cnt_reset", cnt_reset8, 0);
         check("bp_hold_cnt_data", cnt_data8, 0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_no_same_cycle_grant", req_ready8, 0);
      @(negedge clk);
      #1;
      check("bp_next_grant", req_ready8, 4'b1000);
      @(negedge clk);
      req_valid8 = '0;
      n = 0;
      while (rsp_valid8 !== 1'b1 && n < 50) begin
         @(negedge clk); n++;
      end
      check("bp_second_id", rsp_id8, 3);
      check("bp_second_count", rsp_count8, 4);

      // Reset in the middle of SHIFT aborts the transfer.
      @(negedge clk);
      req_data8[16 +: 8] = 8'hFF;
      req_valid8 = 4'b0100;
      #1;
      check("rst_mid_grant", req_ready8, 4'b0100);
      @(negedge clk);
      req_valid8 = '0;
      repeat (3) @(negedge clk);
      check("rst_mid_in_shift", busy8, 1);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_busy", busy8, 0);
      check("rst_mid_cnt_reset", cnt_reset8, 1);
      check("rst_mid_rsp_valid", rsp_valid8, 0);
      reset = 1'b0;
      req_valid8 = 4'hF;
      #1;
      check("rst_ptr_zero", req_ready8, 4'b0001);
      @(negedge clk);
      req_valid8 = '0;
      n = 0;
      while (rsp_valid8 !== 1'b1 && n < 50) begin
         @(negedge clk); n++;
      end
      check("post_rst_id", rsp_id8, 0);
      check("post_rst_count", rsp_count8, 2);

      // Fifteen-bit boundary words.
      xact15(0, 15'h7FFF, 15);
      xact15(1, 15'h0000, 0);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
